id_ex_ctrl_pipe: RTL and testbench

Pipelined successor to the single-cycle opcode decoder. It decodes the ID-stage opcode, registers the control word into the ID/EX and EX/MEM stages, and detects RAW hazards against the in-flight EX and MEM instructions. It inserts bubbles on stall or taken-branch flush and keeps a saturating stall-cycle counter. It sits between the IF/ID register and the EX stage of the 5-stage core.

---
 rtl/id_ex_ctrl_pipe.sv | 198 +++++++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: ID-stage opcode decode, ID/EX and EX/MEM control
// registers, RAW hazard detection with bubble insertion on stall or
// taken-branch flush, and a saturating stall-cycle counter.
// Optional feature macro: FORWARDING_EN (when defined, only load-use
// dependencies stall; otherwise any EX or MEM writer of a used source stalls).
module id_ex_ctrl_pipe #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             opcode,
    input  logic [REG_AW-1:0]      src1,
    input  logic [REG_AW-1:0]      src2,
    input  logic [REG_AW-1:0]      dest,
    input  logic                   freeze,
    input  logic                   br_taken,
    output logic                   hazard_stall,
    output logic [3:0]             ex_exe_cmd,
    output logic                   ex_is_immediate,
    output logic                   ex_mem_r_en,
    output logic                   ex_mem_w_en,
    output logic                   ex_wb_en,
    output logic                   ex_is_single_src,
    output logic                   ex_is_bne,
    output logic [1:0]             ex_br_type,
    output logic [REG_AW-1:0]      ex_dest,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       is_immediate;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       is_single_src;
        logic       is_bne;
        logic [1:0] br_type;
        logic       uses_src1;
        logic       uses_src2;
    } ctrl_t;

    // Opcode map; unknown opcodes decode to an all-zero word (NOP)
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100: begin
                c.wb_en     = 1'b1;
                c.uses_src1 = 1'b1;
                c.uses_src2 = 1'b1;
                case (op)
                    6'b000011: c.exe_cmd = 4'b0010;
                    6'b000101: c.exe_cmd = 4'b0100;
                    6'b000110: c.exe_cmd = 4'b0101;
                    6'b000111: c.exe_cmd = 4'b0110;
                    6'b001000: c.exe_cmd = 4'b0111;
                    6'b001001,
                    6'b001010: c.exe_cmd = 4'b1000;
                    6'b001011: c.exe_cmd = 4'b1001;
                    6'b001100: c.exe_cmd = 4'b1010;
                    default:   c.exe_cmd = 4'b0000;
                endcase
            end
            6'b100000, 6'b100001, 6'b100100: begin
                c.exe_cmd       = (op == 6'b100001) ? 4'b0010 : 4'b0000;
                c.wb_en         = 1'b1;
                c.is_immediate  = 1'b1;
                c.is_single_src = 1'b1;
                c.mem_r_en      = (op == 6'b100100);
                c.uses_src1     = 1'b1;
            end
            6'b100101: begin
                c.mem_w_en     = 1'b1;
                c.is_immediate = 1'b1;
                c.uses_src1    = 1'b1;
                c.uses_src2    = 1'b1;
            end
            6'b101000: begin
                c.is_immediate = 1'b1;
                c.br_type      = 2'b01;
                c.uses_src1    = 1'b1;
            end
            6'b101001: begin
                c.is_immediate = 1'b1;
                c.br_type      = 2'b10;
                c.is_bne       = 1'b1;
                c.uses_src1    = 1'b1;
                c.uses_src2    = 1'b1;
            end
            6'b101010: begin
                c.is_immediate = 1'b1;
                c.br_type      = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // A used, nonzero source equal to a writing stage's destination
    function automatic logic src_match(input logic used, input logic [REG_AW-1:0] src,
                                       input logic wb, input logic [REG_AW-1:0] dst);
        return used && (src != '0) && wb && (src == dst);
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_t             id_ctrl;
    logic              mem_wb_en;
    logic [REG_AW-1:0] mem_dest;
    logic              match_ex;
    logic              match_mem;
    logic              raw_hazard;
    logic              bubble;

    assign id_ctrl = decode(opcode);

    // Per-stage source matches against the in-flight writers
    always_comb begin
        match_ex  = src_match(id_ctrl.uses_src1, src1, ex_wb_en, ex_dest)
                  | src_match(id_ctrl.uses_src2, src2, ex_wb_en, ex_dest);
        match_mem = src_match(id_ctrl.uses_src1, src1, mem_wb_en, mem_dest)
                  | src_match(id_ctrl.uses_src2, src2, mem_wb_en, mem_dest);
`ifdef FORWARDING_EN
        // ALU results are forwarded; only a load in EX cannot be
        raw_hazard = ex_mem_r_en & match_ex;
`else
        raw_hazard = match_ex | match_mem;
`endif
    end

    // A flush suppresses the stall: the dependent instruction is being discarded
    assign hazard_stall = raw_hazard & ~br_taken;
    assign bubble       = br_taken | hazard_stall;

    // ---- ID/EX stage boundary: decoded word or bubble ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_exe_cmd       <= '0;
            ex_is_immediate  <= 1'b0;
            ex_mem_r_en      <= 1'b0;
            ex_mem_w_en      <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_is_single_src <= 1'b0;
            ex_is_bne        <= 1'b0;
            ex_br_type       <= '0;
            ex_dest          <= '0;
        end else if (!freeze) begin
            if (bubble) begin
                ex_exe_cmd       <= '0;
                ex_is_immediate  <= 1'b0;
                ex_mem_r_en      <= 1'b0;
                ex_mem_w_en      <= 1'b0;
                ex_wb_en         <= 1'b0;
                ex_is_single_src <= 1'b0;
                ex_is_bne        <= 1'b0;
                ex_br_type       <= '0;
                ex_dest          <= '0;
            end else begin
                ex_exe_cmd       <= id_ctrl.exe_cmd;
                ex_is_immediate  <= id_ctrl.is_immediate;
                ex_mem_r_en      <= id_ctrl.mem_r_en;
                ex_mem_w_en      <= id_ctrl.mem_w_en;
                ex_wb_en         <= id_ctrl.wb_en;
                ex_is_single_src <= id_ctrl.is_single_src;
                ex_is_bne        <= id_ctrl.is_bne;
                ex_br_type       <= id_ctrl.br_type;
                ex_dest          <= dest;
            end
        end
    end

    // ---- EX/MEM stage boundary: advances even while ID is stalled ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_en <= 1'b0;
            mem_dest  <= '0;
        end else if (!freeze) begin
            mem_wb_en <= ex_wb_en;
            mem_dest  <= ex_dest;
        end
    end

    // Count non-frozen stall cycles, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!freeze && hazard_stall) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: decode table sweep, hand-written
// hazard/flush/freeze/saturation/reset sequences and randomized traffic
// against an instruction-level reference model.
module tb_id_ex_ctrl_pipe;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode;
    logic [AW-1:0] src1, src2, dest;
    logic          freeze, br_taken;

    logic          hazard_stall, hazard_stall2;
    logic [3:0]    ex_exe_cmd, ex_exe_cmd2;
    logic          ex_is_immediate, ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_single_src, ex_is_bne;
    logic          ex_is_immediate2, ex_mem_r_en2, ex_mem_w_en2, ex_wb_en2, ex_is_single_src2, ex_is_bne2;
    logic [1:0]    ex_br_type, ex_br_type2;
    logic [AW-1:0] ex_dest, ex_dest2;
    logic [15:0]   stall_count;
    logic [1:0]    stall_count2;

    id_ex_ctrl_pipe dut (
        .clk(clk), .rst(rst), .opcode(opcode), .src1(src1), .src2(src2), .dest(dest),
        .freeze(freeze), .br_taken(br_taken), .hazard_stall(hazard_stall),
        .ex_exe_cmd(ex_exe_cmd), .ex_is_immediate(ex_is_immediate), .ex_mem_r_en(ex_mem_r_en),
        .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en), .ex_is_single_src(ex_is_single_src),
        .ex_is_bne(ex_is_bne), .ex_br_type(ex_br_type), .ex_dest(ex_dest),
        .stall_count(stall_count)
    );

    id_ex_ctrl_pipe #(.REG_AW(AW), .STALL_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .opcode(opcode), .src1(src1), .src2(src2), .dest(dest),
        .freeze(freeze), .br_taken(br_taken), .hazard_stall(hazard_stall2),
        .ex_exe_cmd(ex_exe_cmd2), .ex_is_immediate(ex_is_immediate2), .ex_mem_r_en(ex_mem_r_en2),
        .ex_mem_w_en(ex_mem_w_en2), .ex_wb_en(ex_wb_en2), .ex_is_single_src(ex_is_single_src2),
        .ex_is_bne(ex_is_bne2), .ex_br_type(ex_br_type2), .ex_dest(ex_dest2),
        .stall_count(stall_count2)
    );

    always #5 clk = ~clk;

    // Decode table: opcode (input) and the expected control word plus source usage
    typedef struct {
        logic [5:0] op;
        logic [3:0] cmd;
        logic       imm, mr, mw, wb, ss, bne;
        logic [1:0] br;
        logic       u1, u2;
    } dec_t;

    typedef struct {
        logic [3:0]    cmd;
        logic          imm, mr, mw, wb, ss, bne;
        logic [1:0]    br;
        logic [AW-1:0] dest;
    } word_t;

    dec_t  tbl[18];
    word_t m_ex, m_mem;
    int    m_cnt, m_cnt2;
    int    checks = 0;
    int    failures = 0;

    function automatic dec_t ent(input logic [5:0] op, input logic [3:0] cmd, input logic [5:0] f,
                                 input logic [1:0] br, input logic [1:0] u);
        dec_t d;
        d.op = op; d.cmd = cmd;
        {d.imm, d.mr, d.mw, d.wb, d.ss, d.bne} = f;
        d.br = br; {d.u1, d.u2} = u;
        return d;
    endfunction

    function automatic dec_t lookup(input logic [5:0] op);
        dec_t d;
        d = ent(op, 4'b0000, 6'b0, 2'b00, 2'b00);
        for (int i = 0; i < 18; i++) if (tbl[i].op == op) d = tbl[i];
        return d;
    endfunction

    function automatic word_t mkword(input dec_t d, input logic [AW-1:0] dst);
        word_t w;
        w.cmd = d.cmd; w.imm = d.imm; w.mr = d.mr; w.mw = d.mw; w.wb = d.wb;
        w.ss = d.ss; w.bne = d.bne; w.br = d.br; w.dest = dst;
        return w;
    endfunction

    function automatic word_t zword();
        return mkword(ent(6'b0, 4'b0, 6'b0, 2'b0, 2'b0), '0);
    endfunction

    function automatic logic [16:0] wpack(input word_t w);
        return {w.cmd, w.imm, w.mr, w.mw, w.wb, w.ss, w.bne, w.br, w.dest};
    endfunction

    function automatic logic [16:0] dut_word();
        return {ex_exe_cmd, ex_is_immediate, ex_mem_r_en, ex_mem_w_en, ex_wb_en,
                ex_is_single_src, ex_is_bne, ex_br_type, ex_dest};
    endfunction

    function automatic logic [16:0] dut2_word();
        return {ex_exe_cmd2, ex_is_immediate2, ex_mem_r_en2, ex_mem_w_en2, ex_wb_en2,
                ex_is_single_src2, ex_is_bne2, ex_br_type2, ex_dest2};
    endfunction

    // Does the instruction in ID read a register an older in-flight instruction will write?
    function automatic logic reads(input logic u, input logic [AW-1:0] s, input word_t w);
        return u && s != 0 && w.wb && w.dest == s;
    endfunction

    function automatic logic model_stall();
        dec_t d;
        logic dep_ex, dep_mem, raw;
        d = lookup(opcode);
        dep_ex  = reads(d.u1, src1, m_ex)  || reads(d.u2, src2, m_ex);
        dep_mem = reads(d.u1, src1, m_mem) || reads(d.u2, src2, m_mem);
`ifdef FORWARDING_EN
        raw = dep_ex && m_ex.mr;
`else
        raw = dep_ex || dep_mem;
`endif
        return raw && !br_taken;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input int s1, input int s2, input int d,
                         input logic fr, input logic br);
        opcode = op; src1 = AW'(s1); src2 = AW'(s2); dest = AW'(d);
        freeze = fr; br_taken = br;
        #1;
    endtask

    // One clock: check the stall on the low phase, advance the model at the edge, check state after it
    task automatic cycle();
        logic st;
        @(negedge clk);
        st = model_stall();
        chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, st});
        chk("hazard_stall_w2", {31'b0, hazard_stall2}, {31'b0, st});
        @(posedge clk);
        if (!freeze) begin
            m_mem = m_ex;
            m_ex  = (br_taken || st) ? zword() : mkword(lookup(opcode), dest);
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        chk("ex_word", {15'b0, dut_word()}, {15'b0, wpack(m_ex)});
        chk("ex_word_w2", {15'b0, dut2_word()}, {15'b0, wpack(m_ex)});
        chk("stall_count", {16'b0, stall_count}, m_cnt);
        chk("stall_count_w2", {30'b0, stall_count2}, m_cnt2);
    endtask

    // Assert reset (possibly mid-cycle) and check that everything clears at once
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_word", {15'b0, dut_word()}, 32'd0);
        chk("rst_count", {16'b0, stall_count}, 32'd0);
        chk("rst_count_w2", {30'b0, stall_count2}, 32'd0);
        chk("rst_hazard", {31'b0, hazard_stall}, 32'd0);
        m_ex = zword(); m_mem = zword(); m_cnt = 0; m_cnt2 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [16:0] saved_word;
    logic [15:0] saved_cnt;
    int          cnt0;

    initial begin
        tbl[0]  = ent(6'b000001, 4'b0000, 6'b000100, 2'b00, 2'b11); // ADD
        tbl[1]  = ent(6'b000011, 4'b0010, 6'b000100, 2'b00, 2'b11); // SUB
        tbl[2]  = ent(6'b000101, 4'b0100, 6'b000100, 2'b00, 2'b11); // AND
        tbl[3]  = ent(6'b000110, 4'b0101, 6'b000100, 2'b00, 2'b11); // OR
        tbl[4]  = ent(6'b000111, 4'b0110, 6'b000100, 2'b00, 2'b11); // NOR
        tbl[5]  = ent(6'b001000, 4'b0111, 6'b000100, 2'b00, 2'b11); // XOR
        tbl[6]  = ent(6'b001001, 4'b1000, 6'b000100, 2'b00, 2'b11); // SLA
        tbl[7]  = ent(6'b001010, 4'b1000, 6'b000100, 2'b00, 2'b11); // SLL
        tbl[8]  = ent(6'b001011, 4'b1001, 6'b000100, 2'b00, 2'b11); // SRA
        tbl[9]  = ent(6'b001100, 4'b1010, 6'b000100, 2'b00, 2'b11); // SRL
        tbl[10] = ent(6'b100000, 4'b0000, 6'b100110, 2'b00, 2'b10); // ADDI
        tbl[11] = ent(6'b100001, 4'b0010, 6'b100110, 2'b00, 2'b10); // SUBI
        tbl[12] = ent(6'b100100, 4'b0000, 6'b110110, 2'b00, 2'b10); // LD
        tbl[13] = ent(6'b100101, 4'b0000, 6'b101000, 2'b00, 2'b11); // ST
        tbl[14] = ent(6'b101000, 4'b0000, 6'b100000, 2'b01, 2'b10); // BEZ
        tbl[15] = ent(6'b101001, 4'b0000, 6'b100001, 2'b10, 2'b11); // BNE
        tbl[16] = ent(6'b101010, 4'b0000, 6'b100000, 2'b11, 2'b00); // JMP
        tbl[17] = ent(6'b111111, 4'b0000, 6'b000000, 2'b00, 2'b00); // unknown -> NOP

        rst = 1'b0;
        drive(6'b0, 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Decode sweep: sources 0 so nothing can stall; dest varies per entry
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].op, 0, 0, i + 1, 1'b0, 1'b0);
            cycle();
            chk("decode", {15'b0, dut_word()}, {15'b0, wpack(mkword(tbl[i], AW'(i + 1)))});
        end

        do_reset();
`ifdef FORWARDING_EN
        // Load-use: one stall, one bubble, then the ADD
        drive(6'b100100, 0, 0, 3, 1'b0, 1'b0); cycle();
        drive(6'b000001, 3, 0, 5, 1'b0, 1'b0);
        chk("lu_stall", {31'b0, hazard_stall}, 32'd1);
        cycle();
        chk("lu_bubble", {15'b0, dut_word()}, 32'd0);
        chk("lu_stall_off", {31'b0, hazard_stall}, 32'd0);
        cycle();
        chk("lu_add_cmd", {28'b0, ex_exe_cmd}, 32'd0);
        chk("lu_add_wb", {31'b0, ex_wb_en}, 32'd1);
        chk("lu_count", {16'b0, stall_count}, 32'd1);
`else
        // Back-to-back ALU dependency: two stalls, two bubbles
        drive(6'b000001, 0, 0, 4, 1'b0, 1'b0); cycle();
        drive(6'b000011, 0, 4, 5, 1'b0, 1'b0);
        chk("nf_stall1", {31'b0, hazard_stall}, 32'd1);
        cycle();
        chk("nf_bubble1", {15'b0, dut_word()}, 32'd0);
        chk("nf_stall2", {31'b0, hazard_stall}, 32'd1);
        cycle();
        chk("nf_bubble2", {15'b0, dut_word()}, 32'd0);
        chk("nf_stall_off", {31'b0, hazard_stall}, 32'd0);
        cycle();
        chk("nf_sub_cmd", {28'b0, ex_exe_cmd}, 32'd2);
        chk("nf_count", {16'b0, stall_count}, 32'd2);
`endif
        // Register 0 never causes a hazard
        cnt0 = int'(stall_count);
        drive(6'b000001, 0, 0, 0, 1'b0, 1'b0); cycle();
        drive(6'b000001, 0, 0, 6, 1'b0, 1'b0);
        chk("r0_no_stall", {31'b0, hazard_stall}, 32'd0);
        cycle();
        chk("r0_count", {16'b0, stall_count}, cnt0);

        // Flush priority over a load-use stall
        drive(6'b100100, 0, 0, 4, 1'b0, 1'b0); cycle();
        cnt0 = int'(stall_count);
        drive(6'b000001, 4, 0, 7, 1'b0, 1'b1);
        chk("flush_no_stall", {31'b0, hazard_stall}, 32'd0);
        cycle();
        chk("flush_bubble", {15'b0, dut_word()}, 32'd0);
        chk("flush_count", {16'b0, stall_count}, cnt0);

        // Freeze with a pending hazard: everything holds, stall still driven
        drive(6'b100100, 0, 0, 4, 1'b0, 1'b0); cycle();
        drive(6'b000001, 4, 0, 7, 1'b1, 1'b0);
        saved_word = dut_word();
        saved_cnt  = stall_count;
        for (int k = 0; k < 5; k++) begin
            chk("freeze_stall", {31'b0, hazard_stall}, 32'd1);
            cycle();
            chk("freeze_word", {15'b0, dut_word()}, {15'b0, saved_word});
            chk("freeze_count", {16'b0, stall_count}, {16'b0, saved_cnt});
        end

        // Repeated loads with dependents drive the 2-bit counter to saturation
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(6'b100100, 0, 0, 7, 1'b0, 1'b0); cycle();
            drive(6'b000001, 7, 0, 8, 1'b0, 1'b0); cycle();
            cycle();
`ifndef FORWARDING_EN
            cycle();
`endif
        end
        chk("sat_count", {30'b0, stall_count2}, 32'd3);
        chk("wide_count_unsat", {31'b0, (stall_count > 16'd3)}, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int idx;
            logic [5:0] op;
            idx = int'($urandom_range(0, 19));
            op  = (idx < 18) ? tbl[idx].op : 6'($urandom);
            drive(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0));
            cycle();
        end

        // Reset asserted mid-stall clears state and drops the stall
        drive(6'b100100, 0, 0, 4, 1'b0, 1'b0); cycle();
        drive(6'b000001, 4, 0, 5, 1'b0, 1'b0);
        chk("pre_rst_stall", {31'b0, hazard_stall}, 32'd1);
        #1;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
